// File: rtl/decode_pipe.sv
// decode_pipe: RV32I/M/Zicsr decode stage with registered output bundle and 1-entry skid buffer
module decode_pipe #(
   parameter int XLEN   = 32,
   parameter bit EN_M   = 1'b1,
   parameter bit EN_CSR = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     instruction,
   input  logic [XLEN-1:0] pc,
   output logic            id_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] pc_out,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   output logic [4:0]      rd_addr,
   output logic [XLEN-1:0] imm,
   output logic [3:0]      alu_control,
   output logic [2:0]      mdu_control,
   output logic [2:0]      csr_control,
   output logic [11:0]     csr_addr,
   output logic            reg_write,
   output logic            mem_write,
   output logic            mem_read,
   output logic            branch,
   output logic            jump,
   output logic            use_imm,
   output logic            illegal
);
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_SLL   = 4'd2;
   localparam logic [3:0] ALU_SLT   = 4'd3;
   localparam logic [3:0] ALU_SLTU  = 4'd4;
   localparam logic [3:0] ALU_XOR   = 4'd5;
   localparam logic [3:0] ALU_SRL   = 4'd6;
   localparam logic [3:0] ALU_SRA   = 4'd7;
   localparam logic [3:0] ALU_OR    = 4'd8;
   localparam logic [3:0] ALU_AND   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic [3:0]      alu;
      logic [2:0]      mdu;
      logic [2:0]      csr;
      logic [11:0]     csr_addr;
      logic            reg_write;
      logic            mem_write;
      logic            mem_read;
      logic            branch;
      logic            jump;
      logic            use_imm;
      logic            illegal;
   } bundle_t;

   logic [6:0]      opcode, f7;
   logic [2:0]      f3;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [3:0]      alu_f3;
   logic            bad;
   bundle_t         dec, ob, sb;
   logic            skid_valid, accept, adv, id_nxt, skid_nxt, out_load, skid_load;

   assign opcode = instruction[6:0];
   assign f3     = instruction[14:12];
   assign f7     = instruction[31:25];
   assign imm_i  = XLEN'($signed(instruction[31:20]));
   assign imm_s  = XLEN'($signed({instruction[31:25], instruction[11:7]}));
   assign imm_b  = XLEN'($signed({instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}));
   assign imm_u  = XLEN'($signed({instruction[31:12], 12'b0}));
   assign imm_j  = XLEN'($signed({instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}));

   // funct3 to ALU op for the register/immediate arithmetic groups (SRL base, SRA picked by funct7)
   always_comb begin
      case (f3)
         3'b000:  alu_f3 = ALU_ADD;
         3'b001:  alu_f3 = ALU_SLL;
         3'b010:  alu_f3 = ALU_SLT;
         3'b011:  alu_f3 = ALU_SLTU;
         3'b100:  alu_f3 = ALU_XOR;
         3'b101:  alu_f3 = ALU_SRL;
         3'b110:  alu_f3 = ALU_OR;
         default: alu_f3 = ALU_AND;
      endcase
   end

   // decode the incoming beat; illegal encodings keep fields but lose all side-effect flags
   always_comb begin
      dec     = '0;
      bad     = 1'b0;
      dec.pc  = pc;
      dec.rs1 = instruction[19:15];
      dec.rs2 = instruction[24:20];
      case (opcode)
         7'b0110111: begin
            dec.imm = imm_u; dec.alu = ALU_PASSB; dec.use_imm = 1'b1; dec.reg_write = 1'b1;
         end
         7'b0010111: begin
            dec.imm = imm_u; dec.use_imm = 1'b1; dec.reg_write = 1'b1;
         end
         7'b1101111: begin
            dec.imm = imm_j; dec.use_imm = 1'b1; dec.reg_write = 1'b1; dec.jump = 1'b1;
         end
         7'b1100111: begin
            dec.imm = imm_i; dec.use_imm = 1'b1; dec.reg_write = 1'b1; dec.jump = 1'b1;
         end
         7'b1100011: begin
            dec.imm = imm_b; dec.branch = 1'b1; bad = f3[2:1] == 2'b01;
         end
         7'b0000011: begin
            dec.imm = imm_i; dec.use_imm = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
            bad = f3 == 3'b011 || f3[2:1] == 2'b11;
         end
         7'b0100011: begin
            dec.imm = imm_s; dec.use_imm = 1'b1; dec.mem_write = 1'b1;
            bad = f3[2] || f3 == 3'b011;
         end
         7'b0010011: begin
            dec.imm = imm_i; dec.use_imm = 1'b1; dec.reg_write = 1'b1;
            dec.alu = (f3 == 3'b101 && f7[5]) ? ALU_SRA : alu_f3;
            bad = (f3 == 3'b001 && f7 != 7'b0) || (f3 == 3'b101 && (f7 & 7'b1011111) != 7'b0);
         end
         7'b0110011: begin
            dec.reg_write = 1'b1;
            case (f7)
               7'b0000000: dec.alu = alu_f3;
               7'b0100000: begin
                  dec.alu = f3 == 3'b101 ? ALU_SRA : ALU_SUB;
                  bad = f3 != 3'b000 && f3 != 3'b101;
               end
               7'b0000001: begin
                  dec.mdu = f3; bad = !EN_M;
               end
               default: bad = 1'b1;
            endcase
         end
         7'b0001111: ;
         7'b1110011: begin
            if (f3 != 3'b000) begin
               dec.csr = f3; dec.csr_addr = instruction[31:20]; dec.reg_write = 1'b1;
               dec.use_imm = f3[2]; dec.imm = f3[2] ? XLEN'(instruction[19:15]) : '0;
               bad = !EN_CSR;
            end
         end
         default: bad = 1'b1;
      endcase
      if (bad) begin
         dec.illegal   = 1'b1;
         dec.reg_write = 1'b0;
         dec.mem_write = 1'b0;
         dec.mem_read  = 1'b0;
         dec.branch    = 1'b0;
         dec.jump      = 1'b0;
         dec.mdu       = 3'd0;
         dec.csr       = 3'd0;
         dec.csr_addr  = 12'd0;
      end
      dec.rd = dec.reg_write ? instruction[11:7] : 5'd0;
   end

   assign accept    = if_valid && if_ready && !flush;
   assign adv       = !id_valid || ex_ready;
   assign id_nxt    = !flush && (!adv || skid_valid || accept);
   assign skid_nxt  = !flush && (accept ? (skid_valid || !adv) : (skid_valid && !adv));
   assign out_load  = !flush && adv && (skid_valid || accept);
   assign skid_load = accept && (skid_valid || !adv);

   // output register and skid buffer; if_ready is simply "skid will be empty"
   always_ff @(posedge clk) begin
      if (!reset) begin
         id_valid   <= 1'b0;
         skid_valid <= 1'b0;
         if_ready   <= 1'b0;
         ob         <= '0;
         sb         <= '0;
      end else begin
         id_valid   <= id_nxt;
         skid_valid <= skid_nxt;
         if_ready   <= !skid_nxt;
         if (out_load) ob <= skid_valid ? sb : dec;
         if (skid_load) sb <= dec;
      end
   end

   assign pc_out      = ob.pc;
   assign rs1_addr    = ob.rs1;
   assign rs2_addr    = ob.rs2;
   assign rd_addr     = ob.rd;
   assign imm         = ob.imm;
   assign alu_control = ob.alu;
   assign mdu_control = ob.mdu;
   assign csr_control = ob.csr;
   assign csr_addr    = ob.csr_addr;
   assign reg_write   = ob.reg_write;
   assign mem_write   = ob.mem_write;
   assign mem_read    = ob.mem_read;
   assign branch      = ob.branch;
   assign jump        = ob.jump;
   assign use_imm     = ob.use_imm;
   assign illegal     = ob.illegal;
endmodule

// File: doc/decode_pipe.md
Name: decode_pipe

Overview:
- Parametrised RV32I/M/Zicsr decode stage between fetch and execute.
- Decodes one instruction per cycle into a registered control and immediate bundle.
- Uses a valid/ready handshake on both sides. A 1-entry skid buffer keeps if_ready a pure register output.
- Supports flush, optional M/CSR extensions and illegal-instruction detection.

Parameters:
- XLEN, 32, datapath width of pc/imm. Must be ≥32; imm sign-extends to XLEN.
- EN_M, 1, 1 = decode M-extension (funct7=0000001 on OP). 0 = those encodings are illegal.
- EN_CSR, 1, 1 = decode Zicsr. 0 = SYSTEM opcode with funct3≠0 is illegal.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk rise)
- flush  in  1  kill all held and incoming instructions this cycle
- if_valid  in  1  fetch presents instruction
- if_ready  out  1  decode can accept; registered
- instruction  in  32  instruction word
- pc  in  XLEN  pc of instruction
- id_valid  out  1  output bundle valid
- ex_ready  in  1  execute accepts bundle (stall = ~ex_ready)
- pc_out  out  XLEN  pc of decoded instruction
- rs1_addr, rs2_addr, rd_addr  out  5 each  register fields; rd_addr forced 0 when reg_write=0
- imm  out  XLEN  format-selected immediate
- alu_control  out  4  ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9 PASSB10
- mdu_control  out  3  funct3 of M op, else 0
- csr_control  out  3  funct3 of CSR op, else 0
- csr_addr  out  12  instruction[31:20] for CSR ops, else 0
- reg_write, mem_write, mem_read, branch, jump, use_imm  out  1 each  control flags
- illegal  out  1  unsupported/malformed encoding

Behaviour:
- Reset (reset=0 at clk rise): id_valid=0, skid valid=0, if_ready=0 the cycle of reset, if_ready=1 the first cycle after release. All bundle outputs 0.
- Combinational decode of the input beat:
  - imm: I/S/B/U/J sign-extended per RV spec.
  - CSR immediate forms (funct3[2]=1): imm = zero-extended rs1 field.
  - LUI: alu_control=PASSB. AUIPC/JAL/JALR: ADD. Loads/stores: ADD with use_imm=1.
  - OP-IMM shifts take shamt in instruction[24:20].
  - Shifts with instruction[25]=1 are illegal.
- Illegal cases: unknown opcode, bad funct7, bad funct3 for load/store/branch, or disabled extension.
  - Sets illegal=1 and clears reg_write, mem_write, mem_read, branch, jump.
  - Still delivered as a valid beat so execute can trap.
- Latency: 1 cycle. Beat accepted at edge N appears with id_valid=1 after edge N.
- Acceptance: accept = if_valid & if_ready & ~flush.
- Output register load: on accept, when (~id_valid | ex_ready).
  - If skid is valid, output loads from skid and the new beat goes to skid.
  - Otherwise the new beat loads the output directly.
- Output held: on accept with id_valid & ~ex_ready, the beat goes to skid and if_ready drops next cycle.
- Skid drain: ex_ready with skid valid and no accept moves skid into output; if_ready returns to 1 next cycle.
- Ordering: strictly in-order. Output bundle and pc_out never change while id_valid & ~ex_ready.
- Flush:
  - Next cycle: id_valid=0 and skid cleared; the same-cycle input beat is dropped.
  - if_ready=1 next cycle. Flush has priority over ex_ready and accept.
- Bundle outputs may hold stale values when id_valid=0; the bench checks them only under id_valid.

Test Plan:
- Reset and ADDI: hold reset=0 for 2 cycles, then release. if_ready=1. Apply 0xFFB10093 (addi x1,x2,-5), pc=0x100.
  - Next cycle: id_valid=1, rd=1, rs1=2, imm=0xFFFFFFFB, alu=ADD, use_imm=1, reg_write=1, pc_out=0x100.
- MUL with EN_M=1, then with EN_M=0: apply 0x022081B3.
  - EN_M=1: mdu_control=0, rd=3, reg_write=1, illegal=0.
  - EN_M=0: illegal=1, reg_write=0.
- CSRRW: apply 0x300312F3.
  - csr_control=1, csr_addr=0x300, rs1=6, rd=5, reg_write=1.
- Backpressure: ex_ready=0 and stream 3 beats (pc 0x0, 0x4, 0x8).
  - Beat 0 held in output, beat 1 in skid, if_ready=0.
  - Raise ex_ready: pc_out sequence 0x0, 0x4, 0x8 with no loss or duplication.
- Flush: with output and skid both full, pulse flush together with if_valid.
  - Next cycle: id_valid=0, if_ready=1, and the flushed beats never appear.
- Illegal: apply 0x00000000.
  - id_valid=1, illegal=1, all write/branch/jump flags 0.
